kbd_ps2_rx: RTL and testbench

PS/2 keyboard receiver that deserialises host-bound scan-code frames, tracks break (F0) and extended (E0) prefixes, and emits a one-cycle `f` pulse when the F key is pressed. It sits directly upstream of the screen-flash stage, whose `f` input it drives. It runs in the `vga_clk` domain and synchronises the asynchronous PS/2 lines internally.

---
 rtl/kbd_ps2_rx.sv | 200 ++++++++++++++++++++
 tb/tb_kbd_ps2_rx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/kbd_ps2_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deserialises frames, tracks F0/E0 prefixes and pulses f on the F key.
// Optional build macro KBD_TYPEMATIC_FILTER_EN suppresses f on typematic repeats of the same make code.
module kbd_ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] F_CODE = 8'h2B
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       f,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity across the data byte and its parity bit.
  function automatic logic parity_ok(input logic [7:0] byte_v, input logic par_v);
    return ^{byte_v, par_v};
  endfunction

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic          filt_r, filt_prev_r;
  logic [3:0]    filt_cnt_r;
  logic          fall_s;
  state_t        state_r, state_nxt_s, fsm_nxt_s;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          par_r;
  logic [TW-1:0] to_cnt_r;
  logic          timeout_s, stop_edge_s, frame_ok_s, suppress_s;
  logic          ext_pend_r, brk_pend_r;
  logic [7:0]    scan_code_r;
  logic          code_valid_r, is_break_r, is_ext_r, f_r, frame_err_r;

  assign scan_code  = scan_code_r;
  assign code_valid = code_valid_r;
  assign is_break   = is_break_r;
  assign is_ext     = is_ext_r;
  assign f          = f_r;
  assign frame_err  = frame_err_r;

  // Two-flop synchronisers for both PS/2 lines.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: a new clock level is taken only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= 4'd0;
    end else begin
      filt_prev_r <= filt_r;
      if (clk_sync_r != filt_r) begin
        if (filt_cnt_r == 4'(FILTER_LEN - 1)) begin
          filt_r     <= clk_sync_r;
          filt_cnt_r <= 4'd0;
        end else begin
          filt_cnt_r <= filt_cnt_r + 4'd1;
        end
      end else begin
        filt_cnt_r <= 4'd0;
      end
    end
  end

  assign fall_s      = filt_prev_r & ~filt_r;
  // A falling edge clears the timer, so a STOP edge beats a coincident terminal count.
  assign timeout_s   = (state_r != ST_IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign stop_edge_s = (state_r == ST_STOP) && fall_s;
  assign frame_ok_s  = data_sync_r && parity_ok(shift_r, par_r);

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic [8:0] last_make_r;
  logic       last_vld_r;
  assign suppress_s = last_vld_r && (last_make_r == {ext_pend_r, shift_r});
`else
  assign suppress_s = 1'b0;
`endif

  // Frame-level next-state logic; a timeout overrides everything and returns to IDLE.
  always_comb begin
    fsm_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (fall_s && !data_sync_r)           fsm_nxt_s = ST_DATA;   else fsm_nxt_s = ST_IDLE;
      ST_DATA:   if (fall_s && (bit_cnt_r == 3'd7))    fsm_nxt_s = ST_PARITY; else fsm_nxt_s = ST_DATA;
      ST_PARITY: if (fall_s)                           fsm_nxt_s = ST_STOP;   else fsm_nxt_s = ST_PARITY;
      ST_STOP:   if (fall_s)                           fsm_nxt_s = ST_IDLE;   else fsm_nxt_s = ST_STOP;
      default:                                         fsm_nxt_s = ST_IDLE;
    endcase
    state_nxt_s = timeout_s ? ST_IDLE : fsm_nxt_s;
  end

  // State register.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bit capture and inactivity timer.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      par_r     <= 1'b0;
      to_cnt_r  <= '0;
    end else begin
      if (fall_s || (state_r == ST_IDLE)) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end
      if (fall_s && (state_r == ST_IDLE)) begin
        bit_cnt_r <= 3'd0;
      end else if (fall_s && (state_r == ST_DATA)) begin
        shift_r   <= {data_sync_r, shift_r[7:1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else if (fall_s && (state_r == ST_PARITY)) begin
        par_r <= data_sync_r;
      end
    end
  end

  // Byte acceptance, prefix tracking and registered output pulses.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      scan_code_r  <= 8'd0;
      code_valid_r <= 1'b0;
      is_break_r   <= 1'b0;
      is_ext_r     <= 1'b0;
      f_r          <= 1'b0;
      frame_err_r  <= 1'b0;
      ext_pend_r   <= 1'b0;
      brk_pend_r   <= 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
      last_make_r  <= 9'd0;
      last_vld_r   <= 1'b0;
`endif
    end else begin
      code_valid_r <= 1'b0;
      f_r          <= 1'b0;
      frame_err_r  <= 1'b0;
      if (timeout_s || (stop_edge_s && !frame_ok_s)) begin
        frame_err_r <= 1'b1;
        ext_pend_r  <= 1'b0;
        brk_pend_r  <= 1'b0;
      end else if (stop_edge_s) begin
        if (shift_r == 8'hE0) begin
          ext_pend_r <= 1'b1;
        end else if (shift_r == 8'hF0) begin
          brk_pend_r <= 1'b1;
        end else begin
          scan_code_r  <= shift_r;
          is_break_r   <= brk_pend_r;
          is_ext_r     <= ext_pend_r;
          code_valid_r <= 1'b1;
          f_r          <= (shift_r == F_CODE) && !brk_pend_r && !ext_pend_r && !suppress_s;
          ext_pend_r   <= 1'b0;
          brk_pend_r   <= 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
          if (!brk_pend_r) begin
            last_make_r <= {ext_pend_r, shift_r};
            last_vld_r  <= 1'b1;
          end else if (suppress_s) begin
            last_vld_r  <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_kbd_ps2_rx.sv
// Directed testbench for kbd_ps2_rx: scan-code frames, prefixes, parity error, timeout, held key and clock glitch.
module tb_kbd_ps2_rx;

  localparam int HALF = 10;
`ifdef KBD_TYPEMATIC_FILTER_EN
  localparam int EXP_F_HELD    = 1;
  localparam int EXP_F_RESUME  = 0;
`else
  localparam int EXP_F_HELD    = 3;
  localparam int EXP_F_RESUME  = 1;
`endif

  logic       vga_clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, is_break, is_ext, f, frame_err;

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0, n_f = 0, n_err = 0;
  int b_valid, b_f, b_err;
  logic [7:0] snap_code = 8'd0;
  logic       snap_brk = 1'b0, snap_ext = 1'b0;

  kbd_ps2_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(300), .F_CODE(8'h2B)) dut (
    .vga_clk(vga_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .code_valid(code_valid), .is_break(is_break),
    .is_ext(is_ext), .f(f), .frame_err(frame_err)
  );

  always #5 vga_clk = ~vga_clk;

  // Pulse counters and a snapshot of the qualifiers at each code_valid.
  always @(negedge vga_clk) begin
    if (code_valid) begin
      n_valid  = n_valid + 1;
      snap_code = scan_code;
      snap_brk  = is_break;
      snap_ext  = is_ext;
    end
    if (f)         n_f   = n_f + 1;
    if (frame_err) n_err = n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge vga_clk);
    ps2_data = b;
    repeat (HALF) @(negedge vga_clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge vga_clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(bad_par ? ^code : ~^code);
    send_bit(1'b1);
    repeat (20) @(negedge vga_clk);
  endtask

  task automatic mark();
    b_valid = n_valid;
    b_f     = n_f;
    b_err   = n_err;
  endtask

  initial begin
    repeat (5) @(negedge vga_clk);
    chk("rst_scan_code", 32'(scan_code), 32'h00);
    chk("rst_pulses", 32'({code_valid, f, frame_err}), 32'h0);
    chk("rst_quals", 32'({is_break, is_ext}), 32'h0);
    reset = 1'b1;
    repeat (20) @(negedge vga_clk);
    chk("rel_no_pulse", 32'(n_valid + n_f + n_err), 32'd0);

    mark(); send_frame(8'h2B, 1'b0);
    chk("make_valid", 32'(n_valid - b_valid), 32'd1);
    chk("make_f", 32'(n_f - b_f), 32'd1);
    chk("make_code", 32'(snap_code), 32'h2B);
    chk("make_quals", 32'({snap_brk, snap_ext}), 32'h0);

    mark(); send_frame(8'hF0, 1'b0); send_frame(8'h2B, 1'b0);
    chk("brk_valid", 32'(n_valid - b_valid), 32'd1);
    chk("brk_f", 32'(n_f - b_f), 32'd0);
    chk("brk_quals", 32'({snap_brk, snap_ext}), 32'h2);

    mark(); send_frame(8'hE0, 1'b0); send_frame(8'h2B, 1'b0);
    chk("ext_valid", 32'(n_valid - b_valid), 32'd1);
    chk("ext_f", 32'(n_f - b_f), 32'd0);
    chk("ext_quals", 32'({snap_brk, snap_ext}), 32'h1);
    mark(); send_frame(8'h2B, 1'b0);
    chk("plain_quals", 32'({snap_brk, snap_ext}), 32'h0);
    chk("plain_f", 32'(n_f - b_f), 32'd1);

    mark(); send_frame(8'h1C, 1'b1);
    chk("par_err", 32'(n_err - b_err), 32'd1);
    chk("par_no_valid", 32'(n_valid - b_valid), 32'd0);
    chk("par_code_held", 32'(scan_code), 32'h2B);

    // Abandon a frame after the fourth data bit and let the timer expire.
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (400) @(negedge vga_clk);
    chk("to_err", 32'(n_err - b_err), 32'd1);
    chk("to_no_valid", 32'(n_valid - b_valid), 32'd0);
    mark(); send_frame(8'h2B, 1'b0);
    chk("to_next_valid", 32'(n_valid - b_valid), 32'd1);
    chk("to_next_code", 32'(snap_code), 32'h2B);
    chk("to_next_f", 32'(n_f - b_f), 32'(EXP_F_RESUME));
    chk("to_next_err", 32'(n_err - b_err), 32'd0);

    send_frame(8'hF0, 1'b0); send_frame(8'h2B, 1'b0);
    mark();
    for (int k = 0; k < 3; k++) send_frame(8'h2B, 1'b0);
    chk("held_valid", 32'(n_valid - b_valid), 32'd3);
    chk("held_f", 32'(n_f - b_f), 32'(EXP_F_HELD));

    // One-cycle clock glitch with data low must not start a frame.
    mark();
    @(negedge vga_clk); ps2_data = 1'b0;
    repeat (3) @(negedge vga_clk); ps2_clk = 1'b0;
    @(negedge vga_clk); ps2_clk = 1'b1;
    repeat (10) @(negedge vga_clk); ps2_data = 1'b1;
    repeat (10) @(negedge vga_clk);
    send_frame(8'h1C, 1'b0);
    chk("glitch_valid", 32'(n_valid - b_valid), 32'd1);
    chk("glitch_code", 32'(snap_code), 32'h1C);
    chk("glitch_err", 32'(n_err - b_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
